// File: rtl/sdram_pkg.sv
// Shared SDRAM write-path types and sizing constants.
package sdram_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int WORD_W     = 32;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    POP  = 2'd2,
    TAIL = 2'd3
  } SeqState;

endpackage

// File: rtl/burst_timeout_counter.sv
// Idle timer for partial bursts. timeout_flag fires on the cycle the
// timer steps onto rollover-1, so a request lands rollover cycles after
// the last clear.
module burst_timeout_counter (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] rollover,
  output logic       timeout_flag
);

  logic [7:0] timer_q, timer_d;

  // Next timer value: clear wins, otherwise count (saturating) while enabled.
  always_comb begin
    timer_d = timer_q;
    if (clr)
      timer_d = '0;
    else if (en && timer_q != 8'hFF)
      timer_d = timer_q + 8'd1;
  end

  // Timer register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) timer_q <= '0;
    else        timer_q <= timer_d;
  end

  // 9-bit compare avoids underflow when rollover is 1.
  assign timeout_flag = en && !clr &&
                        (({1'b0, timer_q} + 9'd2) >= {1'b0, rollover});

endmodule

// File: rtl/wfifo_burst_sequencer.sv
// Drains the SDRAM write-data FIFO into bursts of 1-4 words: tracks
// occupancy from push/pop strobes, requests a burst on full, flush or
// timeout, and pops the latched length after grant.
module wfifo_burst_sequencer
  import sdram_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              fifo_write_enable,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_rdata,
  input  logic              burst_grant,
  input  logic              flush,
  output logic              fifo_read_enable,
  output logic              burst_req,
  output logic [CNT_W-1:0]  burst_len,
  output logic [WORD_W-1:0] sd_wdata,
  output logic              sd_wvalid,
  output logic              busy
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  SeqState          state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] burst_len_q, burst_len_d;
  logic             sd_wvalid_q, sd_wvalid_d;
  logic             push, pop;
  logic             tmr_clr, tmr_en, timeout_flag;

  assign push = fifo_write_enable;
  assign pop  = fifo_read_enable;

  // Occupancy: simultaneous push+pop cancels; saturate at both ends.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   if (count_q != FULL_CNT) count_d = count_q + 3'd1;
      2'b01:   if (count_q != '0)       count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Timer only runs while parked in IDLE with a partial load.
  assign tmr_en  = (state_q == IDLE) && (count_q != '0) && (count_q != FULL_CNT);
  assign tmr_clr = push || (count_q == '0) || (state_q != IDLE);

  burst_timeout_counter u_tmo (
    .clk          (clk),
    .n_rst        (n_rst),
    .clr          (tmr_clr),
    .en           (tmr_en),
    .rollover     (8'(TIMEOUT_CYCLES)),
    .timeout_flag (timeout_flag)
  );

  // Next-state: latch length on request, pop it out, one TAIL cycle for the last word.
  always_comb begin
    state_d     = state_q;
    burst_len_d = burst_len_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (count_q == FULL_CNT ||
            (count_q != '0 && (flush || timeout_flag))) begin
          state_d     = REQ;
          burst_len_d = count_q;
          remaining_d = count_q;
        end
      end
      REQ:  if (burst_grant) state_d = POP;
      POP: begin
        if (remaining_q != '0) remaining_d = remaining_q - 3'd1;
        if (remaining_q <= 3'd1) state_d = TAIL;
      end
      TAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sd_wvalid_d = fifo_read_enable;

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      remaining_q <= '0;
      burst_len_q <= '0;
      sd_wvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      burst_len_q <= burst_len_d;
      sd_wvalid_q <= sd_wvalid_d;
    end
  end

  assign burst_req        = (state_q == REQ);
  assign fifo_read_enable = (state_q == POP);
  assign busy             = (state_q != IDLE);
  assign burst_len        = burst_len_q;
  assign sd_wvalid        = sd_wvalid_q;
  assign sd_wdata         = fifo_rdata;

  // Never pop an empty FIFO.
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!n_rst)
    !(fifo_read_enable && fifo_empty));

  // Writer must not push into a full FIFO without a matching pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (!n_rst)
    !(fifo_write_enable && !fifo_read_enable && count_q == FULL_CNT));

endmodule

// File: tb/tb_wfifo_burst_sequencer.sv
// Directed bench for wfifo_burst_sequencer with a small FIFO model.
module tb_wfifo_burst_sequencer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        fifo_write_enable;
  logic        fifo_empty;
  logic [31:0] fifo_rdata;
  logic        burst_grant;
  logic        flush;
  logic        fifo_read_enable;
  logic        burst_req;
  logic [2:0]  burst_len;
  logic [31:0] sd_wdata;
  logic        sd_wvalid;
  logic        busy;
  logic [31:0] push_data;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  wfifo_burst_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .fifo_write_enable (fifo_write_enable),
    .fifo_empty        (fifo_empty),
    .fifo_rdata        (fifo_rdata),
    .burst_grant       (burst_grant),
    .flush             (flush),
    .fifo_read_enable  (fifo_read_enable),
    .burst_req         (burst_req),
    .burst_len         (burst_len),
    .sd_wdata          (sd_wdata),
    .sd_wvalid         (sd_wvalid),
    .busy              (busy)
  );

  // 4-deep FIFO with registered read data, reset by the same n_rst.
  logic [31:0] fq[$];
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fq.delete();
      fifo_rdata <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_read_enable && fq.size() != 0) fifo_rdata <= fq.pop_front();
      if (fifo_write_enable && fq.size() < 4) fq.push_back(push_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    fifo_write_enable = 1'b1;
    push_data         = d;
    step();
    fifo_write_enable = 1'b0;
  endtask

  // Cycles from now until burst_req is seen (bounded).
  task automatic wait_req(input string tag, input int exp_n);
    int n;
    n = 0;
    while (!burst_req && n < 64) begin
      step();
      n++;
    end
    chk({tag, "_req_lat"}, 32'(n), 32'(exp_n));
  endtask

  // Grant after gdelay cycles, then watch pops, data, busy and length.
  task automatic run_burst(input string tag, input int len, input int gdelay,
                           input int push_at, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [31:0] w2,
                           input logic [31:0] w3);
    logic [31:0] exp_w[4];
    logic [31:0] got_w[$];
    int npop, first_pop, busy_low, len_bad;
    exp_w     = '{w0, w1, w2, w3};
    npop      = 0;
    first_pop = -1;
    busy_low  = -1;
    len_bad   = 0;
    chk({tag, "_len"}, 32'(burst_len), 32'(len));
    repeat (gdelay) step();
    chk({tag, "_req_held"}, 32'(burst_req), 32'd1);
    burst_grant = 1'b1;
    step();
    burst_grant = 1'b0;
    for (int k = 1; k <= len + 3; k++) begin
      fifo_write_enable = (k == push_at);
      push_data         = 32'hB0;
      if (fifo_read_enable) begin
        npop++;
        if (first_pop < 0) first_pop = k;
      end
      if (sd_wvalid) got_w.push_back(sd_wdata);
      if (busy && burst_len != 3'(len)) len_bad++;
      if (!busy && busy_low < 0) busy_low = k;
      step();
    end
    fifo_write_enable = 1'b0;
    chk({tag, "_npop"},      32'(npop),         32'(len));
    chk({tag, "_first_pop"}, 32'(first_pop),    32'd1);
    chk({tag, "_busy_low"},  32'(busy_low),     32'(len + 2));
    chk({tag, "_len_stable"},32'(len_bad),      32'd0);
    chk({tag, "_nwords"},    32'(got_w.size()), 32'(len));
    for (int i = 0; i < len; i++)
      chk({tag, "_word"}, (i < got_w.size()) ? got_w[i] : 32'hDEAD_DEAD, exp_w[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    n_rst = 1'b0;
    fifo_write_enable = 1'b0;
    burst_grant = 1'b0;
    flush = 1'b0;
    push_data = '0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      fifo_write_enable = 1'($urandom);
      burst_grant       = 1'($urandom);
      flush             = 1'($urandom);
      push_data         = $urandom;
      step();
      chk("rst_outs", {25'b0, burst_req, burst_len, fifo_read_enable, sd_wvalid, busy}, 32'd0);
    end
    chk("rst_wdata", sd_wdata, 32'd0);
    fifo_write_enable = 1'b0;
    burst_grant = 1'b0;
    flush = 1'b0;
    n_rst = 1'b1;
    seen = 0;
    repeat (20) begin
      step();
      if (burst_req) seen++;
    end
    chk("idle_no_req", 32'(seen), 32'd0);

    // Full burst of four, grant two cycles after request.
    push(32'hA0); push(32'hA1); push(32'hA2); push(32'hA3);
    wait_req("full", 1);
    run_burst("full", 4, 2, 0, 32'hA0, 32'hA1, 32'hA2, 32'hA3);

    // Two words then idle: timeout forces a partial burst.
    push(32'hC0); push(32'hC1);
    wait_req("tmo", 15);
    run_burst("tmo", 2, 0, 0, 32'hC0, 32'hC1, 32'h0, 32'h0);

    // One word then flush.
    push(32'h55);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_req("flush", 0);
    run_burst("flush", 1, 0, 0, 32'h55, 32'h0, 32'h0, 32'h0);

    // Flush with nothing queued is ignored.
    flush = 1'b1;
    step();
    flush = 1'b0;
    seen = 0;
    repeat (20) begin
      step();
      if (burst_req) seen++;
    end
    chk("flush_empty", 32'(seen), 32'd0);

    // Push during POP: length stays 4, leftover word leaves via timeout.
    push(32'hD0); push(32'hD1); push(32'hD2); push(32'hD3);
    wait_req("ppush", 1);
    run_burst("ppush", 4, 0, 1, 32'hD0, 32'hD1, 32'hD2, 32'hD3);
    wait_req("left", 13);
    run_burst("left", 1, 0, 0, 32'hB0, 32'h0, 32'h0, 32'h0);

    // Reset in the second POP cycle aborts the burst.
    push(32'hE0); push(32'hE1); push(32'hE2); push(32'hE3);
    wait_req("abort", 1);
    burst_grant = 1'b1;
    step();
    burst_grant = 1'b0;
    step();
    chk("abort_in_pop", 32'(fifo_read_enable), 32'd1);
    n_rst = 1'b0;
    step();
    chk("abort_outs", {25'b0, burst_req, burst_len, fifo_read_enable, sd_wvalid, busy}, 32'd0);
    chk("abort_wdata", sd_wdata, 32'd0);
    n_rst = 1'b1;
    step();
    push(32'hF0); push(32'hF1); push(32'hF2); push(32'hF3);
    wait_req("post", 1);
    run_burst("post", 4, 0, 0, 32'hF0, 32'hF1, 32'hF2, 32'hF3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/wfifo_burst_sequencer.md
# wfifo_burst_sequencer

Drains the 4-deep, 32-bit SDRAM write-data FIFO into SDRAM write bursts. Tracks FIFO occupancy from the push/pop strobes and requests a burst when four words are queued, when partial data has waited too long, or on an explicit flush. On grant from the SDRAM command scheduler, it pops exactly the latched number of words and presents them, with a valid strobe, on the SDRAM write-data path.

## Interface
- TIMEOUT_CYCLES, 16: idle cycles with 1–3 queued words before a partial burst is forced; legal range 1–255.
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- fifo_write_enable  in  1  writer's push strobe into the FIFO, observed for occupancy tracking.
- fifo_empty  in  1  FIFO empty flag; used only for the assertion check.
- fifo_rdata  in  32  FIFO registered read data, valid one cycle after a pop.
- burst_grant  in  1  scheduler accepts the pending burst request; single-cycle pulse.
- flush  in  1  force the pending partial burst now.
- fifo_read_enable  out  1  pop strobe to the FIFO.
- burst_req  out  1  burst request to the scheduler.
- burst_len  out  3  words in the requested burst, 1–4.
- sd_wdata  out  32  write data to SDRAM; equals fifo_rdata.
- sd_wvalid  out  1  sd_wdata is a burst word this cycle.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Occupancy counter `count` (0–4):
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged.
  - push while count=4 and no pop: protocol violation; count saturates at 4 and the violation is flagged by an assertion.
- Idle timer (8 bits):
  - counts only in IDLE while 1 ≤ count ≤ 3.
  - clears on any push, when count=0, and on leaving IDLE.
- State machine:
  - IDLE → REQ when count=4, when flush=1 and count>0, or when the timer reaches TIMEOUT_CYCLES−1 with count>0. On that transition, burst_len ← count and remaining ← count.
  - IDLE with count=0 ignores flush.
  - REQ: burst_req=1, held until burst_grant. On grant → POP. burst_grant outside REQ is ignored.
  - POP: fifo_read_enable=1 every cycle; remaining decrements each cycle. When remaining=1 → TAIL.
  - TAIL: no pop. The last word's sd_wvalid is high this cycle. Next state is IDLE.
- sd_wvalid is fifo_read_enable delayed by one register; sd_wdata = fifo_rdata passes through combinationally.
- Pushes during REQ, POP or TAIL update count but never change the latched burst_len. Leftover words start a fresh decision back in IDLE.
- flush outside IDLE is ignored, not remembered.
- Assertion: fifo_read_enable is never high while fifo_empty=1.

## Timing
- Reset values:
  - state=IDLE; count=0; timer=0; remaining=0.
  - burst_req=0, burst_len=0, fifo_read_enable=0, sd_wvalid=0, busy=0.
  - sd_wdata follows fifo_rdata, which the FIFO resets to 0.
- Trigger seen at cycle T: burst_req rises at T+1.
- Grant in cycle G:
  - fifo_read_enable high G+1..G+len.
  - sd_wvalid high G+2..G+len+1.
  - TAIL at G+len+1; busy low at G+len+2.
- burst_len is stable from REQ entry through TAIL.
- Back-to-back: the earliest next burst_req is one cycle after returning to IDLE.
- Asynchronous reset mid-burst: aborts immediately and returns to reset values. The FIFO is reset by the same n_rst, so count=0 stays consistent.

## Structure
- Shared package `sdram_pkg`:
  - enum `SeqState` {IDLE, REQ, POP, TAIL}.
  - constant `FIFO_DEPTH=4`.
  - constant `WORD_W=32`.
- One natural sub-module, `burst_timeout_counter`: timer with clear, enable, and a rollover-value input; outputs timeout_flag.
- Occupancy counter and FSM stay in the top module.

## Test plan
- Reset held with random inputs → all outputs 0, busy=0; release → no burst_req with no pushes.
- Push 0xA0..0xA3 on four consecutive cycles, grant 2 cycles after burst_req → burst_len=4; sd_wvalid for 4 cycles carrying 0xA0, 0xA1, 0xA2, 0xA3 in order; busy low 2 cycles after the last pop.
- Push 2 words, then idle with TIMEOUT_CYCLES=16 → burst_req exactly 16 cycles after the last push, burst_len=2, two words out.
- Push 1 word (0x55), pulse flush the next cycle → burst_req the following cycle, burst_len=1, sd_wdata=0x55 with one sd_wvalid; flush with count=0 → no request.
- Full burst of 4 with one push of 0xB0 during POP → burst_len stays 4, count ends at 1, timer restarts; 0xB0 goes out in a later length-1 burst.
- Assert n_rst in the second POP cycle → next edge shows every output at its reset value; a fresh 4-word push then produces a normal length-4 burst.
